// File: rtl/system_pll_0_reconfig_ctrl.sv
// Run-time retune sequencer for the system_pll_0 fractional PLL: drives the
// reconfig core's Avalon-MM port through counter writes, start, status poll and lock wait.
module system_pll_0_reconfig_ctrl #(
    parameter int POLL_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        req,
    input  logic [17:0] n_cfg,
    input  logic [17:0] m_cfg,
    input  logic [17:0] c0_cfg,
    output logic        req_ack,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C, WR_START, RD_STAT, WAIT_LOCK, DONE
    } state_t;

    localparam logic [23:0] POLL_LIM   = 24'(POLL_TIMEOUT);
    localparam logic [23:0] LOCK_LIM   = 24'(LOCK_TIMEOUT);
    localparam logic [23:0] STABLE_LIM = 24'(LOCK_STABLE);

    state_t      state, state_nx;
    logic [17:0] n_q, m_q, c0_q, n_nx, m_nx, c0_nx;
    logic [23:0] poll_cnt, stable_cnt, total_cnt;
    logic [23:0] poll_nx, stable_nx, total_nx;
    logic [23:0] poll_inc, stable_inc, total_inc;
    logic        sync1, locked_s;
    logic        ack_nx, busy_nx, done_nx, wr_nx, rd_nx;
    logic [1:0]  err_nx;
    logic [5:0]  addr_nx;
    logic [31:0] wdata_nx;
    logic        wr_ok, rd_ok;
    logic        unused_rd;

    assign unused_rd = ^mgmt_readdata[31:1];

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == '1) ? v : v + 24'd1;
    endfunction

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            n_q            <= '0;
            m_q            <= '0;
            c0_q           <= '0;
            poll_cnt       <= '0;
            stable_cnt     <= '0;
            total_cnt      <= '0;
            req_ack        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_code       <= 2'd0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
        end else begin
            state          <= state_nx;
            n_q            <= n_nx;
            m_q            <= m_nx;
            c0_q           <= c0_nx;
            poll_cnt       <= poll_nx;
            stable_cnt     <= stable_nx;
            total_cnt      <= total_nx;
            req_ack        <= ack_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            err_code       <= err_nx;
            mgmt_address   <= addr_nx;
            mgmt_write     <= wr_nx;
            mgmt_read      <= rd_nx;
            mgmt_writedata <= wdata_nx;
        end
    end

    // Outputs are computed one cycle ahead so every port leaves a flop.
    always_comb begin
        state_nx   = state;
        n_nx       = n_q;
        m_nx       = m_q;
        c0_nx      = c0_q;
        poll_nx    = poll_cnt;
        stable_nx  = stable_cnt;
        total_nx   = total_cnt;
        ack_nx     = 1'b0;
        busy_nx    = busy;
        done_nx    = 1'b0;
        err_nx     = err_code;
        addr_nx    = mgmt_address;
        wr_nx      = mgmt_write;
        rd_nx      = mgmt_read;
        wdata_nx   = mgmt_writedata;
        wr_ok      = mgmt_write & ~mgmt_waitrequest;
        rd_ok      = mgmt_read & ~mgmt_waitrequest;
        poll_inc   = sat_inc(poll_cnt);
        stable_inc = locked_s ? sat_inc(stable_cnt) : 24'd0;
        total_inc  = sat_inc(total_cnt);

        case (state)
            IDLE: if (req) begin
                state_nx = WR_MODE;
                n_nx     = n_cfg;
                m_nx     = m_cfg;
                c0_nx    = c0_cfg;
                ack_nx   = 1'b1;
                busy_nx  = 1'b1;
                err_nx   = 2'd0;
                wr_nx    = 1'b1;
                addr_nx  = 6'h00;
                wdata_nx = 32'h1;
            end
            WR_MODE: if (wr_ok) begin
                state_nx = WR_N;
                addr_nx  = 6'h03;
                wdata_nx = {14'b0, n_q};
            end
            WR_N: if (wr_ok) begin
                state_nx = WR_M;
                addr_nx  = 6'h04;
                wdata_nx = {14'b0, m_q};
            end
            WR_M: if (wr_ok) begin
                state_nx = WR_C;
                addr_nx  = 6'h05;
                wdata_nx = {9'b0, 5'd0, c0_q};
            end
            WR_C: if (wr_ok) begin
                state_nx = WR_START;
                addr_nx  = 6'h02;
                wdata_nx = 32'h1;
            end
            WR_START: if (wr_ok) begin
                state_nx = RD_STAT;
                wr_nx    = 1'b0;
                wdata_nx = '0;
                rd_nx    = 1'b1;
                addr_nx  = 6'h01;
                poll_nx  = '0;
            end
            RD_STAT: begin
                poll_nx = poll_inc;
                if (rd_ok && mgmt_readdata[0]) begin
                    state_nx  = WAIT_LOCK;
                    rd_nx     = 1'b0;
                    stable_nx = '0;
                    total_nx  = '0;
                end else if (poll_inc >= POLL_LIM) begin
                    state_nx = DONE;
                    rd_nx    = 1'b0;
                    err_nx   = 2'd1;
                    done_nx  = 1'b1;
                end else if (rd_ok) begin
                    rd_nx = 1'b0;
                end else if (!mgmt_read) begin
                    rd_nx = 1'b1;
                end
            end
            WAIT_LOCK: begin
                stable_nx = stable_inc;
                total_nx  = total_inc;
                // A lock that qualifies on the timeout cycle still counts as success.
                if (stable_inc >= STABLE_LIM) begin
                    state_nx = DONE;
                    err_nx   = 2'd0;
                    done_nx  = 1'b1;
                end else if (total_inc >= LOCK_LIM) begin
                    state_nx = DONE;
                    err_nx   = 2'd2;
                    done_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_system_pll_0_reconfig_ctrl.sv
// Directed bench for the PLL reconfig sequencer: nominal run, stalls, timeouts,
// lock glitch, request handling and mid-transfer reset.
module tb_system_pll_0_reconfig_ctrl;

    logic        refclk = 1'b0;
    logic        rst;
    logic        req;
    logic [17:0] n_cfg, m_cfg, c0_cfg;
    logic        req_ack, busy, done;
    logic [1:0]  err_code;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    int errors = 0;
    int checks = 0;

    // per-run observations
    int          wr_n, rd_n, ack_n, last_ack, done_cyc, both, st_cnt;
    logic [1:0]  done_err, err_c1;
    logic        done_rd, busy_after;
    logic [5:0]  wa [16];
    logic [31:0] wd [16];
    logic [5:0]  ea [5];
    logic [31:0] ed [5];

    always #10 refclk = ~refclk;

    system_pll_0_reconfig_ctrl #(
        .POLL_TIMEOUT(8),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (16)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .req             (req),
        .n_cfg           (n_cfg),
        .m_cfg           (m_cfg),
        .c0_cfg          (c0_cfg),
        .req_ack         (req_ack),
        .busy            (busy),
        .done            (done),
        .err_code        (err_code),
        .mgmt_address    (mgmt_address),
        .mgmt_write      (mgmt_write),
        .mgmt_read       (mgmt_read),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_readdata   (mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked)
    );

    // Cycle 0 is the acceptance edge; cycle k is observed at the k-th falling edge after it.
    task automatic run_txn(input bit hold, input int pulse_cyc, input logic [5:0] st_addr,
                           input int st_n, input int glitch_cyc, input int post, input int limit);
        int st_left = st_n;
        int k = 0;
        bit fin = 0;
        logic [31:0] first_d = '0;
        wr_n = 0; rd_n = 0; ack_n = 0; last_ack = -1; done_cyc = -1; both = 0; st_cnt = 0;
        done_err = 2'bx; done_rd = 1'bx; busy_after = 1'bx; err_c1 = 2'bx;
        @(negedge refclk);
        req = 1'b1;
        while (!fin) begin
            @(negedge refclk);
            k++;
            if (!hold && k == 1) req = 1'b0;
            if (pulse_cyc != 0 && k == pulse_cyc) begin
                req = 1'b1; n_cfg = 18'h3ffff; m_cfg = 18'h2aaaa; c0_cfg = 18'h15555;
            end
            if (pulse_cyc != 0 && k == pulse_cyc + 1) req = 1'b0;
            if (glitch_cyc != 0 && k == glitch_cyc) pll_locked = 1'b0;
            if (glitch_cyc != 0 && k == glitch_cyc + 1) pll_locked = 1'b1;
            if (st_left > 0 && mgmt_write && mgmt_address == st_addr) begin
                mgmt_waitrequest = 1'b1;
                st_left--;
            end else begin
                mgmt_waitrequest = 1'b0;
            end
            if (mgmt_write && mgmt_address == st_addr) begin
                if (st_cnt == 0) first_d = mgmt_writedata;
                if (mgmt_writedata == first_d) st_cnt++;
            end
            if (k == 1) err_c1 = err_code;
            if (mgmt_write && mgmt_read) both++;
            if (mgmt_write && !mgmt_waitrequest && wr_n < 16) begin
                wa[wr_n] = mgmt_address;
                wd[wr_n] = mgmt_writedata;
                wr_n++;
            end
            if (mgmt_read && !mgmt_waitrequest) rd_n++;
            if (req_ack) begin ack_n++; last_ack = k; end
            if (done && done_cyc < 0) begin
                done_cyc = k; done_err = err_code; done_rd = mgmt_read;
            end
            if (done_cyc >= 0 && k == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && k >= done_cyc + post) fin = 1;
            if (k >= limit) fin = 1;
        end
        mgmt_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
        mgmt_readdata = 32'h1;
        n_cfg = 18'h10000; m_cfg = 18'h00404; c0_cfg = 18'h00404;
        #25;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || req_ack !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b ack=%b, want 0", busy, done, req_ack);
        end
        checks++; if (err_code !== 2'd0) begin
            errors++; $display("FAIL reset_err: got %0d want 0", err_code);
        end
        checks++; if (mgmt_write !== 1'b0 || mgmt_read !== 1'b0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
            errors++; $display("FAIL reset_mgmt: wr=%b rd=%b addr=%h data=%h, want 0", mgmt_write, mgmt_read, mgmt_address, mgmt_writedata);
        end
        @(negedge refclk); rst = 1'b0;
        repeat (3) @(negedge refclk);
    endtask

    task automatic test_nominal();
        run_txn(0, 0, 6'h3f, 0, 0, 1, 60);
        checks++; if (wr_n !== 5) begin errors++; $display("FAIL nom_wr_count: got %0d want 5", wr_n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                errors++; $display("FAIL nom_write%0d: got (%h,%h) want (%h,%h)", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        checks++; if (rd_n !== 1) begin errors++; $display("FAIL nom_reads: got %0d want 1", rd_n); end
        checks++; if (done_cyc !== 23) begin errors++; $display("FAIL nom_done_cycle: got %0d want 23", done_cyc); end
        checks++; if (done_err !== 2'd0) begin errors++; $display("FAIL nom_err: got %0d want 0", done_err); end
        checks++; if (ack_n !== 1 || last_ack !== 1) begin
            errors++; $display("FAIL nom_ack: got %0d at %0d want 1 at 1", ack_n, last_ack);
        end
        checks++; if (both !== 0) begin errors++; $display("FAIL nom_rd_wr_overlap: got %0d want 0", both); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL nom_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_stall();
        run_txn(0, 0, 6'h04, 3, 0, 1, 60);
        checks++; if (st_cnt !== 4) begin errors++; $display("FAIL stall_hold_cycles: got %0d want 4", st_cnt); end
        checks++; if (wr_n !== 5 || wa[2] !== 6'h04 || wd[2] !== 32'h404) begin
            errors++; $display("FAIL stall_write: count %0d addr %h data %h want 5,04,404", wr_n, wa[2], wd[2]);
        end
        checks++; if (done_cyc !== 26) begin errors++; $display("FAIL stall_done_cycle: got %0d want 26", done_cyc); end
    endtask

    task automatic test_poll_timeout();
        mgmt_readdata = 32'h0;
        run_txn(0, 0, 6'h3f, 0, 0, 1, 60);
        mgmt_readdata = 32'h1;
        checks++; if (done_cyc !== 14) begin errors++; $display("FAIL poll_done_cycle: got %0d want 14", done_cyc); end
        checks++; if (done_err !== 2'd1) begin errors++; $display("FAIL poll_err: got %0d want 1", done_err); end
        checks++; if (wr_n !== 5) begin errors++; $display("FAIL poll_wr_count: got %0d want 5", wr_n); end
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL poll_reads: got %0d want 4", rd_n); end
        checks++; if (done_rd !== 1'b0) begin errors++; $display("FAIL poll_read_in_done: got %b want 0", done_rd); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL poll_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_lock_timeout();
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL err_held: got %0d want 1", err_code); end
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        run_txn(0, 0, 6'h3f, 0, 0, 1, 80);
        pll_locked = 1'b1;
        checks++; if (err_c1 !== 2'd0) begin errors++; $display("FAIL err_clear_on_accept: got %0d want 0", err_c1); end
        checks++; if (done_cyc !== 39) begin errors++; $display("FAIL lockto_done_cycle: got %0d want 39", done_cyc); end
        checks++; if (done_err !== 2'd2) begin errors++; $display("FAIL lockto_err: got %0d want 2", done_err); end
        repeat (3) @(negedge refclk);
    endtask

    task automatic test_lock_glitch();
        run_txn(0, 0, 6'h3f, 0, 10, 1, 80);
        checks++; if (done_cyc !== 29) begin errors++; $display("FAIL glitch_done_cycle: got %0d want 29", done_cyc); end
        checks++; if (done_err !== 2'd0) begin errors++; $display("FAIL glitch_err: got %0d want 0", done_err); end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        run_txn(1, 0, 6'h3f, 0, 0, 2, 60);
        req = 1'b0;
        checks++; if (done_cyc !== 23) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 23", done_cyc); end
        checks++; if (ack_n !== 2 || last_ack !== 25) begin
            errors++; $display("FAIL b2b_acks: got %0d last at %0d want 2 last at 25", ack_n, last_ack);
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge refclk);
            if (done) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_second_done: got none want done"); end
        run_txn(0, 2, 6'h3f, 0, 0, 1, 60);
        checks++; if (ack_n !== 1) begin errors++; $display("FAIL busy_req_ack: got %0d want 1", ack_n); end
        checks++; if (wr_n !== 5 || wd[2] !== 32'h404 || wd[3] !== 32'h404) begin
            errors++; $display("FAIL busy_req_cfg: m=%h c0=%h want 404,404", wd[2], wd[3]);
        end
        n_cfg = 18'h10000; m_cfg = 18'h00404; c0_cfg = 18'h00404;
    endtask

    task automatic test_reset_mid();
        @(negedge refclk);
        req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge refclk);
            if (k == 1) req = 1'b0;
            mgmt_waitrequest = (mgmt_write && mgmt_address == 6'h03);
        end
        checks++; if (mgmt_write !== 1'b1 || mgmt_address !== 6'h03) begin
            errors++; $display("FAIL rstmid_stalled: wr=%b addr=%h want 1,03", mgmt_write, mgmt_address);
        end
        rst = 1'b1;
        #1;
        checks++; if (mgmt_write !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: wr=%b busy=%b want 0,0", mgmt_write, busy);
        end
        @(negedge refclk);
        rst = 1'b0; mgmt_waitrequest = 1'b0;
        run_txn(0, 0, 6'h3f, 0, 0, 1, 60);
        checks++; if (wa[0] !== 6'h00 || wd[0] !== 32'h1) begin
            errors++; $display("FAIL rstmid_restart: got (%h,%h) want (00,1)", wa[0], wd[0]);
        end
        checks++; if (done_cyc !== 23 || done_err !== 2'd0) begin
            errors++; $display("FAIL rstmid_done: cycle %0d err %0d want 23,0", done_cyc, done_err);
        end
    endtask

    initial begin
        ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h02};
        ed = '{32'h1, 32'h10000, 32'h404, 32'h404, 32'h1};
        test_reset();
        test_nominal();
        test_stall();
        test_poll_timeout();
        test_lock_timeout();
        test_lock_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/system_pll_0_reconfig_ctrl.md
# system_pll_0_reconfig_ctrl

Sequencer that retunes the `system_pll_0` Cyclone V fractional PLL at run time. It accepts a request carrying new N, M and C0 counter settings and drives the Altera PLL reconfiguration core over its Avalon-MM management port: polling mode, counter writes, start, status poll. It then waits for the PLL `locked` output to settle and reports success or a timeout error. It sits between system control logic and the PLL reconfig core, which connects to `reconfig_to_pll`/`reconfig_from_pll`.

## Interface
- `POLL_TIMEOUT`, default 4096: maximum cycles spent in status polling before error.
- `LOCK_TIMEOUT`, default 65536: maximum cycles waiting for stable lock before error.
- `LOCK_STABLE`, default 16: consecutive cycles `locked` must read high to count as locked (≥1).

- `refclk` in 1: single clock, 50 MHz management clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: reconfiguration request, level; sampled only in IDLE.
- `n_cfg` in 18: N counter word {odd_en, bypass, hi[7:0], lo[7:0]}.
- `m_cfg` in 18: M counter word, same format.
- `c0_cfg` in 18: C0 counter word, same format.
- `req_ack` out 1: one-cycle pulse when a request is accepted.
- `busy` out 1: high from acceptance until `done`.
- `done` out 1: one-cycle completion pulse, for success or error.
- `err_code` out 2: 0 ok, 1 poll timeout, 2 lock timeout; held until the next acceptance.
- `mgmt_address` out 6: reconfig core address.
- `mgmt_write` out 1: write strobe.
- `mgmt_read` out 1: read strobe.
- `mgmt_writedata` out 32: write data.
- `mgmt_readdata` in 32: read data, valid in the cycle `mgmt_waitrequest` is low with `mgmt_read` high.
- `mgmt_waitrequest` in 1: stall.
- `pll_locked` in 1: PLL `locked`, asynchronous; passes through a 2-flop synchronizer to give `locked_s`.

## Operation
- On acceptance in IDLE (`req`=1), latch `n_cfg`, `m_cfg` and `c0_cfg`; pulse `req_ack`; clear `err_code`.
- States, in order: IDLE → WR_MODE → WR_N → WR_M → WR_C → WR_START → RD_STAT → WAIT_LOCK → DONE → IDLE.
- Write sequence (address, data):
  - WR_MODE: 0x00, 0x1 (polling mode).
  - WR_N: 0x03, {14'b0, n}.
  - WR_M: 0x04, {14'b0, m}.
  - WR_C: 0x05, {9'b0, 5'd0 counter index in [22:18], c0[17:0]}.
  - WR_START: 0x02, 0x1.
- Avalon rule: hold address, data and strobe unchanged while `mgmt_waitrequest`=1. Advance on the first cycle the strobe is high and `mgmt_waitrequest`=0. Never assert read and write together.
- RD_STAT: read address 0x01. If the accepted readdata has [0]=1, go to WAIT_LOCK. Otherwise deassert `mgmt_read` for one cycle and re-read.
- Poll timeout: a poll counter increments every RD_STAT cycle. When it reaches POLL_TIMEOUT, set `err_code`=1 and go to DONE. Any pending read is dropped: strobe low in DONE.
- WAIT_LOCK: a stable counter increments while `locked_s`=1 and clears to 0 when `locked_s`=0. On reaching LOCK_STABLE, go to DONE with `err_code`=0.
- Lock timeout: a total counter increments every WAIT_LOCK cycle. When it reaches LOCK_TIMEOUT, set `err_code`=2 and go to DONE. If both conditions occur in the same cycle, success wins.
- DONE: pulse `done` and return to IDLE. A `req` still high in the IDLE that follows is accepted as a new request.
- `req` outside IDLE is ignored: no ack, no latching.
- Counters are 24-bit and saturate. They clear on entry to RD_STAT and WAIT_LOCK respectively.

## Timing
- Reset values: state IDLE, `req_ack`=0, `busy`=0, `done`=0, `err_code`=0, `mgmt_address`=0, `mgmt_write`=0, `mgmt_read`=0, `mgmt_writedata`=0, synchronizer flops=0.
- Reset is asynchronous: the strobes drop in the same instant reset asserts, including mid-transfer. Release is synchronized externally.
- All outputs are registered.
- Reference latency: zero waitrequest, status ready on the first read, `locked_s` already high.
  - Cycle 0: accept.
  - Cycles 1–5: one write each.
  - Cycle 6: status read.
  - Cycles 7..6+LOCK_STABLE: lock count.
  - `done` at cycle 7+LOCK_STABLE (cycle 23 with the defaults).
- Each waitrequest cycle adds one cycle.
- `locked` edges reach `locked_s` after 2 cycles.

## Test plan
- Nominal: `req`=1 with n=0x10000, m=0x00404, c0=0x00404; waitrequest 0; status=1; locked high. Expected: writes (0,1), (3,0x10000), (4,0x404), (5,0x404), (2,1) in order; one read at 1; `done` at cycle 23; `err_code`=0.
- Stall: waitrequest high for 3 cycles on the WR_M write. Expected: address, data and strobe stable for 4 cycles; `done` at cycle 26.
- Poll timeout: POLL_TIMEOUT=8, status always 0. Expected: `done` with `err_code`=1; no write after the start write; `busy` low the next cycle.
- Lock loss and timeout, two runs:
  - `pll_locked` toggles low once mid-count. Expected: stable counter restarts; `done` delayed by the glitch.
  - LOCK_TIMEOUT=32 with locked held low. Expected: `err_code`=2.
- `req` held high through a full run. Expected: exactly one `req_ack` per IDLE visit; `req` pulsed while busy produces no ack and the latched cfg is unchanged.
- Reset asserted while `mgmt_write` is stalled on WR_N. Expected: `mgmt_write`=0 and `busy`=0 immediately; after release, a fresh `req` restarts from WR_MODE.
